bin_to_bcd_seq: RTL and testbench



---
 rtl/bcd_pkg.sv | 26 ++
 rtl/bcd_digit_adj.sv | 17 +
 rtl/bin_to_bcd_seq.sv | 151 +++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and codes for the BCD display path.
// Digit codes match the downstream 7-segment decoder.
package bcd_pkg;

   localparam int DIGIT_W = 4;

   localparam logic [DIGIT_W-1:0] BCD_OVF_CODE   = 4'hA;
   localparam logic [DIGIT_W-1:0] BCD_BLANK_CODE = 4'hF;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } bcd_state_t;

   // Elaboration-time 10^n for range limits.
   function automatic longint unsigned pow10(input int n);
      longint unsigned r;
      r = 1;
      for (int i = 0; i < n; i++) begin
         r = r * 10;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: one BCD digit,
// add 3 when the digit is 5 or more (no carry out).
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] d,
   output logic [DIGIT_W-1:0] q
);

   always_comb begin
      q = d;
      if (d >= DIGIT_W'(5)) begin
         q = d + DIGIT_W'(3);
      end
   end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary to packed BCD converter.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits.
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 14,
   parameter int DIGITS = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [BIN_W-1:0]          bin_in,
   output logic                      busy,
   output logic                      done,
   output logic [DIGIT_W*DIGITS-1:0] bcd_out,
   output logic                      overflow
);

   localparam int BCD_W = DIGIT_W * DIGITS;
   localparam int SR_W  = BCD_W + BIN_W;
   localparam int CNT_W = $clog2(BIN_W + 1);

   localparam logic [BIN_W-1:0] MAX_VAL =
      BIN_W'(pow10(DIGITS) - 1);

   bcd_state_t state, state_d;

   logic [SR_W-1:0]  sr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ovf_flag_q;
   logic             busy_q;
   logic             done_q;
   logic [BCD_W-1:0] bcd_q;
   logic             overflow_q;

   logic [BCD_W-1:0] adj_bcd;
   logic [SR_W-1:0]  sr_adj;
   logic [SR_W-1:0]  sr_next;
   logic [BCD_W-1:0] raw_bcd;
   logic [BCD_W-1:0] disp_bcd;
   logic [BCD_W-1:0] result;

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_adj
         bcd_digit_adj u_adj (
            .d (sr_q[BIN_W + g*DIGIT_W +: DIGIT_W]),
            .q (adj_bcd[g*DIGIT_W +: DIGIT_W])
         );
      end
   endgenerate

   assign sr_adj  = {adj_bcd, sr_q[BIN_W-1:0]};
   assign sr_next = {sr_adj[SR_W-2:0], 1'b0};
   assign raw_bcd = sr_q[SR_W-1 -: BCD_W];

`ifdef LEADING_ZERO_BLANK_EN
   logic lead;

   // Units digit is never blanked so zero reads as "0".
   always_comb begin
      disp_bcd = raw_bcd;
      lead     = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
         if (raw_bcd[i*DIGIT_W +: DIGIT_W] != '0) begin
            lead = 1'b0;
         end
         if (lead) begin
            disp_bcd[i*DIGIT_W +: DIGIT_W] = BCD_BLANK_CODE;
         end
      end
   end
`else
   assign disp_bcd = raw_bcd;
`endif

   assign result = ovf_flag_q ? {DIGITS{BCD_OVF_CODE}}
                              : disp_bcd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q       <= '0;
         cnt_q      <= '0;
         ovf_flag_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         bcd_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         // Busy also covers the cycle in which done is shown.
         busy_q <= (state_d != IDLE) || (state == DONE);
         unique case (state)
            IDLE: begin
               if (start) begin
                  sr_q       <= {BCD_W'(0), bin_in};
                  cnt_q      <= CNT_W'(BIN_W);
                  ovf_flag_q <= (bin_in > MAX_VAL);
               end
            end
            SHIFT: begin
               sr_q  <= sr_next;
               cnt_q <= cnt_q - CNT_W'(1);
            end
            DONE: begin
               bcd_q      <= result;
               overflow_q <= ovf_flag_q;
               done_q     <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign bcd_out  = bcd_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: vector table, random values
// against a decimal model, and multi-cycle corner cases.
module tb_bin_to_bcd_seq;

   localparam int BIN_W  = 14;
   localparam int DIGITS = 4;

   typedef struct {
      logic [15:0] bcd;
      logic        ovf;
   } exp_t;

   typedef struct {
      logic [13:0] bin;
      logic [15:0] plain;
      logic [15:0] blank;
      logic        ovf;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [13:0] bin_in;
   logic        busy;
   logic        done;
   logic [15:0] bcd_out;
   logic        overflow;

   int n_cmp;
   int n_bad;
   int done_cnt;

   exp_t sbq[$];
   vec_t tbl[13];

   bin_to_bcd_seq #(
      .BIN_W  (BIN_W),
      .DIGITS (DIGITS)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .bin_in   (bin_in),
      .busy     (busy),
      .done     (done),
      .bcd_out  (bcd_out),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(string nm,
                               logic [31:0] got,
                               logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, got, exp);
      end
   endfunction

   function automatic exp_t model(int v);
      exp_t e;
      logic [3:0] d[4];
      logic seen;
      if (v > 9999) begin
         e.bcd = 16'hAAAA;
         e.ovf = 1'b1;
         return e;
      end
      for (int i = 0; i < 4; i++) begin
         d[i] = 4'(v % 10);
         v = v / 10;
      end
`ifdef LEADING_ZERO_BLANK_EN
      seen = 1'b0;
      for (int i = 3; i > 0; i--) begin
         if (d[i] != 4'd0) seen = 1'b1;
         if (!seen) d[i] = 4'hF;
      end
`else
      seen = 1'b0;
`endif
      e.bcd = {d[3], d[2], d[1], d[0]};
      e.ovf = 1'b0;
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done) begin
         done_cnt++;
         if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got bcd %h want none",
                     bcd_out);
         end else begin
            e = sbq.pop_front();
            chk("bcd_out", 32'(bcd_out), 32'(e.bcd));
            chk("overflow", 32'(overflow), 32'(e.ovf));
         end
      end
   end

   task automatic wait_done(output int k);
      k = 0;
      while (!done && k < 40) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout: got %0d cycles want 15", k);
      end
   endtask

   task automatic convert(input logic [13:0] v, input exp_t e);
      int k;
      int bc;
      @(negedge clk);
      start  = 1'b1;
      bin_in = v;
      @(posedge clk);
      sbq.push_back(e);
      #1;
      start = 1'b0;
      bc = busy ? 1 : 0;
      k = 0;
      while (!done && k < 40) begin
         @(posedge clk);
         #1;
         k++;
         if (busy) bc++;
      end
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout: got %0d cycles want 15", k);
         return;
      end
      chk("latency", 32'(k), 32'd15);
      @(posedge clk);
      #1;
      if (busy) bc++;
      chk("busy_cycles", 32'(bc), 32'd16);
   endtask

   initial begin
      exp_t e;
      int   k;
      int   k2;
      int   base;
      int   v;

      n_cmp    = 0;
      n_bad    = 0;
      done_cnt = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      bin_in   = '0;

      tbl[0]  = '{14'd0,     16'h0000, 16'hFFF0, 1'b0};
      tbl[1]  = '{14'd1234,  16'h1234, 16'h1234, 1'b0};
      tbl[2]  = '{14'd9999,  16'h9999, 16'h9999, 1'b0};
      tbl[3]  = '{14'd10000, 16'hAAAA, 16'hAAAA, 1'b1};
      tbl[4]  = '{14'd7,     16'h0007, 16'hFFF7, 1'b0};
      tbl[5]  = '{14'd42,    16'h0042, 16'hFF42, 1'b0};
      tbl[6]  = '{14'd9,     16'h0009, 16'hFFF9, 1'b0};
      tbl[7]  = '{14'd10,    16'h0010, 16'hFF10, 1'b0};
      tbl[8]  = '{14'd100,   16'h0100, 16'hF100, 1'b0};
      tbl[9]  = '{14'd5005,  16'h5005, 16'h5005, 1'b0};
      tbl[10] = '{14'd16383, 16'hAAAA, 16'hAAAA, 1'b1};
      tbl[11] = '{14'd9990,  16'h9990, 16'h9990, 1'b0};
      tbl[12] = '{14'd808,   16'h0808, 16'hF808, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_bcd", 32'(bcd_out), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
         e.bcd = tbl[i].blank;
`else
         e.bcd = tbl[i].plain;
`endif
         e.ovf = tbl[i].ovf;
         convert(tbl[i].bin, e);
      end

      for (int i = 0; i < 16; i++) begin
         v = int'($urandom_range(0, 16383));
         convert(14'(v), model(v));
      end

      // Back-to-back with start held high.
      @(negedge clk);
      start  = 1'b1;
      bin_in = 14'd1234;
      @(posedge clk);
      sbq.push_back(model(1234));
      #1;
      bin_in = 14'd9999;
      wait_done(k);
      chk("b2b_lat1", 32'(k), 32'd15);
      @(posedge clk);
      sbq.push_back(model(9999));
      #1;
      start = 1'b0;
      chk("b2b_busy", 32'(busy), 32'd1);
      wait_done(k2);
      chk("b2b_gap", 32'(k2 + 1), 32'd16);
      repeat (2) @(posedge clk);

      // Start and new data while shifting are ignored.
      base = done_cnt;
      @(negedge clk);
      start  = 1'b1;
      bin_in = 14'd808;
      @(posedge clk);
      sbq.push_back(model(808));
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      start  = 1'b1;
      bin_in = 14'd55;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(k);
      repeat (20) @(posedge clk);
      #1;
      chk("single_done", 32'(done_cnt - base), 32'd1);

      // Reset in the middle of a conversion.
      @(negedge clk);
      start  = 1'b1;
      bin_in = 14'd4321;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_bcd", 32'(bcd_out), 32'd0);
      chk("abort_ovf", 32'(overflow), 32'd0);
      base = done_cnt;
      repeat (20) @(posedge clk);
      #1;
      chk("abort_no_done", 32'(done_cnt - base), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      convert(14'd4321, model(4321));

      repeat (4) @(posedge clk);
      chk("sb_empty", 32'(sbq.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
